ov7670_capture: RTL
===================

Name: ov7670_capture

Overview:
- Receive-side counterpart to the on-chip pixel-tick generator: consumes the OV7670 camera's own pixel clock and sync strobes, not a locally generated tick.
- Synchronises the camera inputs into the 100 MHz system clock and assembles byte pairs into RGB565 pixels.
- Emits one frame-buffer write per pixel, with a linear address.
- Sits between the camera pins and the frame-buffer write port, in the same design as the VGA scan-out path.

Parameters:
- H_ACTIVE, 320, active pixels per line (2*H_ACTIVE bytes per HREF).
- V_ACTIVE, 240, active lines per frame.
- ADDR_W, 17, write-address width; must satisfy 2**ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- cam_pclk  in  1  camera pixel clock, asynchronous to clk, <= 25 MHz.
- cam_vsync  in  1  camera VSYNC, high = vertical blanking.
- cam_href  in  1  camera HREF, high = active line bytes.
- cam_data  in  8  camera data byte.
- we  out  1  frame-buffer write strobe, one clk wide.
- waddr  out  ADDR_W  pixel index, row*H_ACTIVE + col.
- wdata  out  16  RGB565 pixel, {first byte, second byte}.
- frame_done  out  1  one-clk pulse at end of a captured frame.
- overflow  out  1  sticky per frame: pixel dropped past H_ACTIVE*V_ACTIVE.

Behaviour:
- Clock/reset: one clock (clk); reset synchronous, active-high.
- Input sync: cam_pclk, cam_vsync, cam_href and cam_data pass through 2-FF synchronisers. A PCLK rising edge is a cycle where the synced pclk = 1 and its delayed copy = 0. Data and HREF are taken from the synced values in that cycle. clk must be >= 4x cam_pclk.
- Reset values: we=0, waddr=0, wdata=0, frame_done=0, overflow=0. State = WAIT_VS_HIGH; byte phase, pixel counter and line counter cleared.
- States and transitions:
  - WAIT_VS_HIGH: wait for synced vsync = 1 -> WAIT_VS_LOW.
  - WAIT_VS_LOW: on vsync 1->0 -> ACTIVE; clear pixel counter, line counter and overflow.
  - ACTIVE, on a PCLK edge with href = 1:
    - phase 0: latch byte into hi; phase <= 1.
    - phase 1: form {hi, byte} -> wdata; pulse we with the current pixel index; increment index; phase <= 0.
  - ACTIVE, vsync 0->1: pulse frame_done for one clk -> WAIT_VS_LOW.
- HREF falling edge (synced): phase <= 0; any partial hi byte is discarded; line counter increments.
- Latency: we asserts the clk cycle after the detected PCLK edge carrying the second byte, i.e. 3-4 clk after the physical camera edge.
- waddr: equals the count of pixels already written this frame, starting at 0. Continuous across lines; not derived from the line counter.
- Address limit: when the index reaches H_ACTIVE*V_ACTIVE, further completed pixels produce no we; overflow <= 1 until the next frame start.
- Short frame (vsync rises early): frame_done still pulses; the next frame restarts at waddr 0.
- PCLK edge with href = 0: ignored.
- vsync rise coinciding with a PCLK edge on a second byte: the write completes in the same cycle that frame_done pulses.
- Reset mid-frame: return to WAIT_VS_HIGH. No writes occur until a full vsync high->low is seen, so a partial frame is never captured.
- we is never asserted outside ACTIVE.

Optional Feature:
- Macro: OV7670_LINE_CHECK_EN.
- Defined:
  - Adds output line_err (1 bit, sticky per frame, reset 0).
  - Set when an HREF falling edge occurs with a completed-pixel count for that line != H_ACTIVE, or with phase = 1 (odd byte count).
  - Also set when frame_done fires with line count != V_ACTIVE.
  - Cleared at frame start.
- Undefined: no line_err port, no per-line pixel counter; all other behaviour identical.

Test Plan:
- Reset, then 2 full frames at pclk = 25 MHz (320x240, bytes 0x12,0x34 repeating) -> 76800 we pulses per frame, wdata = 0x1234, last waddr = 76799, one frame_done per frame, overflow = 0.
- Reset asserted at pixel 1000 of frame 1 -> no we until after the next vsync high->low; the first write after that has waddr = 0.
- Line with href dropping after 641 bytes -> 320 writes; the 641st byte is discarded; the next line's first pixel waddr = previous + 1, not shifted. With OV7670_LINE_CHECK_EN: line_err = 1.
- Frame of 241 lines -> writes stop at waddr 76799, overflow = 1, frame_done pulses. The next frame clears overflow.
- PCLK toggling with href = 0 during blanking, plus vsync rising 20 lines early -> no spurious we; frame_done pulses once; next frame starts at waddr 0.
- Bytes 0xF8,0x00 then 0x07,0xE0 -> wdata = 0xF800 at waddr 0, then 0x07E0 at waddr 1; each we is exactly one clk wide.

Source files
------------

// File: rtl/ov7670_capture.sv
// OV7670 camera receiver: synchronises PCLK/VSYNC/HREF/DATA into clk and writes RGB565 pixels to a frame buffer.
// Optional per-line/per-frame geometry checking is enabled with `define OV7670_LINE_CHECK_EN.
module ov7670_capture #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [15:0]       wdata,
  output logic              frame_done,
  output logic              overflow
`ifdef OV7670_LINE_CHECK_EN
  ,
  output logic              line_err
`endif
);

  localparam int PIX_TOTAL = H_ACTIVE * V_ACTIVE;
  // One spare bit so the index can hold PIX_TOTAL even when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0] PIX_LIMIT = (ADDR_W + 1)'(PIX_TOTAL);

  typedef enum logic [1:0] {
    WAIT_VS_HIGH,
    WAIT_VS_LOW,
    ACTIVE
  } state_t;

  state_t state, state_next;

  // Bit 0 is the first flop, bit 1 the synchronised value, bit 2 its delayed copy.
  logic [2:0] pclk_sr, vsync_sr, href_sr;
  logic [7:0] data_s1, data_s2;

  logic pclk_rise, vsync_rise, vsync_fall, href_fall;
  logic frame_start, frame_end, capture_byte;

  logic              phase;
  logic [7:0]        hi_byte;
  logic [ADDR_W:0]   pix_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      pclk_sr  <= '0;
      vsync_sr <= '0;
      href_sr  <= '0;
      data_s1  <= '0;
      data_s2  <= '0;
    end else begin
      pclk_sr  <= {pclk_sr[1:0], cam_pclk};
      vsync_sr <= {vsync_sr[1:0], cam_vsync};
      href_sr  <= {href_sr[1:0], cam_href};
      data_s1  <= cam_data;
      data_s2  <= data_s1;
    end
  end

  assign pclk_rise  = pclk_sr[1] & ~pclk_sr[2];
  assign vsync_rise = vsync_sr[1] & ~vsync_sr[2];
  assign vsync_fall = ~vsync_sr[1] & vsync_sr[2];
  assign href_fall  = ~href_sr[1] & href_sr[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_VS_HIGH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    frame_start  = 1'b0;
    frame_end    = 1'b0;
    capture_byte = 1'b0;
    case (state)
      WAIT_VS_HIGH: begin
        if (vsync_sr[1]) state_next = WAIT_VS_LOW;
      end
      WAIT_VS_LOW: begin
        if (vsync_fall) begin
          state_next  = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        capture_byte = pclk_rise & href_sr[1];
        if (vsync_rise) begin
          state_next = WAIT_VS_LOW;
          frame_end  = 1'b1;
        end
      end
      default: state_next = WAIT_VS_HIGH;
    endcase
  end

`ifdef OV7670_LINE_CHECK_EN
  localparam logic [15:0] H_COUNT = 16'(H_ACTIVE);
  localparam logic [15:0] V_COUNT = 16'(V_ACTIVE);

  // The line counters only feed the geometry check, so they exist only in this build.
  logic [15:0] line_cnt, line_pix, lines_seen;

  assign lines_seen = line_cnt + 16'(href_fall);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      phase      <= 1'b0;
      hi_byte    <= '0;
      pix_idx    <= '0;
`ifdef OV7670_LINE_CHECK_EN
      line_cnt   <= '0;
      line_pix   <= '0;
      line_err   <= 1'b0;
`endif
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      if (frame_start) begin
        pix_idx  <= '0;
        phase    <= 1'b0;
        overflow <= 1'b0;
`ifdef OV7670_LINE_CHECK_EN
        line_cnt <= '0;
        line_pix <= '0;
        line_err <= 1'b0;
`endif
      end
      if (capture_byte) begin
        if (!phase) begin
          hi_byte <= data_s2;
          phase   <= 1'b1;
        end else begin
          phase <= 1'b0;
`ifdef OV7670_LINE_CHECK_EN
          line_pix <= line_pix + 16'd1;
`endif
          if (pix_idx < PIX_LIMIT) begin
            we      <= 1'b1;
            waddr   <= pix_idx[ADDR_W-1:0];
            wdata   <= {hi_byte, data_s2};
            pix_idx <= pix_idx + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
      // A line ending mid-pixel drops the orphan high byte so the next line stays aligned.
      if (state == ACTIVE && href_fall) begin
        phase <= 1'b0;
`ifdef OV7670_LINE_CHECK_EN
        line_cnt <= line_cnt + 16'd1;
        line_pix <= '0;
        if (line_pix != H_COUNT || phase) line_err <= 1'b1;
`endif
      end
      if (frame_end) begin
        frame_done <= 1'b1;
`ifdef OV7670_LINE_CHECK_EN
        if (lines_seen != V_COUNT) line_err <= 1'b1;
`endif
      end
    end
  end

endmodule
